rotor_config_ctrl: RTL and testbench

- Controller that owns the position settings of NUM_ROTORS cipher rotors.
- Rotor selection comes from debounced one-hot button presses. Position is edited with single-cycle encoder step pulses.
- On commit, the full setting is handed to the cipher datapath over a valid/ready handshake.
- Sits between the button/encoder front-end pulse FSMs and the rotor datapath.

---
 rtl/rotor_cfg_pkg.sv | 37 +++
 rtl/rotor_config_ctrl_if.sv | 25 ++
 rtl/rotor_pos_step.sv | 47 ++++
 rtl/rotor_config_ctrl.sv | 137 +++++++++++++
 tb/tb_rotor_config_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rotor_cfg_pkg.sv
// Shared types and defaults for the rotor configuration controller.
// Optional odometer stepping is selected elsewhere with ROTOR_CARRY_EN.
package rotor_cfg_pkg;

  localparam int NUM_ROTORS = 8;
  localparam int POS_W      = 5;
  localparam int MAX_POS    = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } onehot_t;

  // Select vectors up to 32 bits wide; callers zero-extend narrower buses.
  function automatic onehot_t onehot_idx(input logic [31:0] sel);
    onehot_t     r;
    int unsigned cnt;
    r.valid = 1'b0;
    r.idx   = '0;
    cnt     = 0;
    for (int i = 0; i < 32; i++) begin
      if (sel[i]) begin
        cnt++;
        r.idx = 5'(i);
      end
    end
    r.valid = (cnt == 1);
    return r;
  endfunction

endpackage

// File: rtl/rotor_config_ctrl_if.sv
// Configuration hand-off channel from the controller to the rotor datapath.
// valid/ready: the master raises cfg_valid with cfg_data and holds both stable
// until the slave samples cfg_ready=1 at a clock edge; that edge is the transfer.
interface rotor_config_ctrl_if #(
  parameter int NUM_ROTORS = rotor_cfg_pkg::NUM_ROTORS,
  parameter int POS_W      = rotor_cfg_pkg::POS_W
) ();

  logic                        cfg_valid;
  logic                        cfg_ready;
  logic [NUM_ROTORS*POS_W-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/rotor_pos_step.sv
// Next-position logic for one rotor: wraps 0..MAX_POS and reports the wrap
// as carry/borrow so neighbouring rotors can chain (ROTOR_CARRY_EN builds).
module rotor_pos_step #(
  parameter int POS_W   = rotor_cfg_pkg::POS_W,
  parameter int MAX_POS = rotor_cfg_pkg::MAX_POS
) (
  input  logic [POS_W-1:0] pos,
  input  logic             inc,
  input  logic             dec,
  input  logic             carry_in,
  input  logic             borrow_in,
  output logic [POS_W-1:0] next_pos,
  output logic             carry_out,
  output logic             borrow_out
);

  localparam logic [POS_W-1:0] MAX_V = POS_W'(MAX_POS);

  logic up;
  logic dn;

  assign up = inc | carry_in;
  assign dn = dec | borrow_in;

  // Opposing requests cancel; the rotor holds.
  always_comb begin
    next_pos   = pos;
    carry_out  = 1'b0;
    borrow_out = 1'b0;
    if (up && !dn) begin
      if (pos == MAX_V) begin
        next_pos  = '0;
        carry_out = 1'b1;
      end else begin
        next_pos = pos + POS_W'(1);
      end
    end else if (dn && !up) begin
      if (pos == '0) begin
        next_pos   = MAX_V;
        borrow_out = 1'b1;
      end else begin
        next_pos = pos - POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/rotor_config_ctrl.sv
// Owns the rotor position settings: button select, encoder edit, commit to the
// datapath over cfg valid/ready. Define ROTOR_CARRY_EN for odometer stepping.
module rotor_config_ctrl
  import rotor_cfg_pkg::*;
#(
  parameter int NUM_ROTORS = rotor_cfg_pkg::NUM_ROTORS,
  parameter int POS_W      = rotor_cfg_pkg::POS_W,
  parameter int MAX_POS    = rotor_cfg_pkg::MAX_POS
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_ROTORS-1:0]       sel_press,
  input  logic                        step_up,
  input  logic                        step_down,
  input  logic                        commit,
  output logic [NUM_ROTORS-1:0]       rotor_sel,
  output logic                        busy,
  rotor_config_ctrl_if.master         cfg,
  output logic [1:0]                  dbg_state,
  output logic [NUM_ROTORS*POS_W-1:0] dbg_pos
);

  localparam int K_W = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EDIT = ST_EDIT;
  localparam logic [1:0] S_SEND = ST_SEND;

  logic [1:0]                  state;
  logic [K_W-1:0]              k_q;
  logic [NUM_ROTORS*POS_W-1:0] pos_flat;
  logic [NUM_ROTORS-1:0]       unused_chain;
  onehot_t                     oh;
  logic                        step_act;

  assign oh = onehot_idx(32'(sel_press));

  // Commit wins over any edit in the same cycle; opposing steps cancel.
  assign step_act = (state == S_EDIT) && !commit && (step_up ^ step_down);

  for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rot
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             hit;
    logic             ci;
    logic             bi;
    logic             co;
    logic             bo;

    assign hit = step_act && (k_q == K_W'(i));

`ifdef ROTOR_CARRY_EN
    if (i == 0) begin : g_first
      assign ci = 1'b0;
      assign bi = 1'b0;
    end else begin : g_chain
      assign ci = g_rot[i-1].co;
      assign bi = g_rot[i-1].bo;
    end
`else
    assign ci = 1'b0;
    assign bi = 1'b0;
`endif

    rotor_pos_step #(
      .POS_W   (POS_W),
      .MAX_POS (MAX_POS)
    ) u_step (
      .pos        (pos_q),
      .inc        (hit && step_up),
      .dec        (hit && step_down),
      .carry_in   (ci),
      .borrow_in  (bi),
      .next_pos   (pos_d),
      .carry_out  (co),
      .borrow_out (bo)
    );

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        pos_q <= '0;
      end else if (step_act) begin
        pos_q <= pos_d;
      end
    end

    assign pos_flat[i*POS_W +: POS_W] = pos_q;
    // Carry/borrow out of the top rotor (or all rotors without chaining) is dropped.
    assign unused_chain[i] = co ^ bo;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      k_q           <= '0;
      rotor_sel     <= '0;
      cfg.cfg_valid <= 1'b0;
      cfg.cfg_data  <= '0;
    end else begin
      case (state)
        S_IDLE, S_EDIT: begin
          if (commit) begin
            state         <= S_SEND;
            rotor_sel     <= '0;
            cfg.cfg_valid <= 1'b1;
            cfg.cfg_data  <= pos_flat;
          end else if (oh.valid) begin
            if ((state == S_EDIT) && (K_W'(oh.idx) == k_q)) begin
              state     <= S_IDLE;
              rotor_sel <= '0;
            end else begin
              state     <= S_EDIT;
              k_q       <= K_W'(oh.idx);
              rotor_sel <= NUM_ROTORS'(1) << oh.idx;
            end
          end
        end
        S_SEND: begin
          if (cfg.cfg_ready) begin
            state         <= S_IDLE;
            cfg.cfg_valid <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          rotor_sel     <= '0;
          cfg.cfg_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state == S_SEND);
  assign dbg_state = state;
  assign dbg_pos   = pos_flat;

endmodule

// File: tb/tb_rotor_config_ctrl.sv
// Directed + randomized bench for rotor_config_ctrl against a positional
// (mixed-radix number) model of the rotor settings.
module tb_rotor_config_ctrl;
  import rotor_cfg_pkg::*;

  localparam int NR    = 8;
  localparam int PW    = 5;
  localparam int MAXP  = 25;
  localparam int RADIX = MAXP + 1;
  localparam int DW    = NR * PW;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] sel_press = '0;
  logic          step_up = 1'b0;
  logic          step_down = 1'b0;
  logic          commit = 1'b0;
  logic [NR-1:0] rotor_sel;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [DW-1:0] dbg_pos;

  always #5 clock = ~clock;

  rotor_config_ctrl_if #(.NUM_ROTORS(NR), .POS_W(PW)) cfg_if ();

  rotor_config_ctrl #(
    .NUM_ROTORS (NR),
    .POS_W      (PW),
    .MAX_POS    (MAXP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sel_press (sel_press),
    .step_up   (step_up),
    .step_down (step_down),
    .commit    (commit),
    .rotor_sel (rotor_sel),
    .busy      (busy),
    .cfg       (cfg_if),
    .dbg_state (dbg_state),
    .dbg_pos   (dbg_pos)
  );

  // ---------------- reference model ----------------
  int            checks = 0;
  int            errors = 0;
  int            mpos[NR];
  int            msel;       // -1 when no rotor is being edited
  bit            msend;
  logic [DW-1:0] mdata;
  logic [DW-1:0] exp_q[$];   // transfers offered but not yet accepted

  function automatic logic [DW-1:0] pack_model();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[i*PW +: PW] = PW'(mpos[i]);
    return r;
  endfunction

  // Settings viewed as one number, rotor i weighted by RADIX**i.
  task automatic apply_step(input int k, input bit up);
`ifdef ROTOR_CARRY_EN
    longint v, m, w;
    v = 0; m = 1; w = 1;
    for (int i = 0; i < NR; i++) begin
      v += longint'(mpos[i]) * m;
      if (i < k) w *= RADIX;
      m *= RADIX;
    end
    v = up ? (v + w) % m : (v - w + m) % m;
    for (int i = 0; i < NR; i++) begin
      mpos[i] = int'(v % RADIX);
      v /= RADIX;
    end
`else
    mpos[k] = up ? (mpos[k] + 1) % RADIX : (mpos[k] + RADIX - 1) % RADIX;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mpos[i] = 0;
    msel  = -1;
    msend = 1'b0;
    mdata = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [NR-1:0] sel, input bit up, input bit dn,
                            input bit cm, input bit rdy);
    int j;
    if (msend) begin
      if (rdy) begin
        msend = 1'b0;
        void'(exp_q.pop_front());
      end
    end else if (cm) begin
      mdata = pack_model();
      exp_q.push_back(mdata);
      msend = 1'b1;
      msel  = -1;
    end else begin
      if (msel >= 0 && (up ^ dn)) apply_step(msel, up);
      if ($countones(sel) == 1) begin
        j = 0;
        for (int i = 0; i < NR; i++) if (sel[i]) j = i;
        msel = (msel == j) ? -1 : j;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NR-1:0] es;
    logic [1:0]    est;
    es  = (msel < 0) ? '0 : NR'(1) << msel;
    est = msend ? ST_SEND : ((msel >= 0) ? ST_EDIT : ST_IDLE);
    check("rotor_sel", 64'(rotor_sel), 64'(es));
    check("cfg_valid", 64'(cfg_if.cfg_valid), 64'(msend));
    check("busy", 64'(busy), 64'(msend));
    check("state", 64'(dbg_state), 64'(est));
    check("positions", 64'(dbg_pos), 64'(pack_model()));
    check("cfg_data", 64'(cfg_if.cfg_data), 64'(mdata));
    if (msend) check("cfg_data_q", 64'(cfg_if.cfg_data), 64'(exp_q[0]));
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input logic [NR-1:0] sel, input bit up, input bit dn,
                     input bit cm, input bit rdy);
    @(negedge clock);
    sel_press        = sel;
    step_up          = up;
    step_down        = dn;
    commit           = cm;
    cfg_if.cfg_ready = rdy;
    @(posedge clock);
    model_step(sel, up, dn, cm, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n          = 1'b0;
    sel_press        = '0;
    step_up          = 1'b0;
    step_down        = 1'b0;
    commit           = 1'b0;
    cfg_if.cfg_ready = 1'b0;
    @(posedge clock);
    model_clear();
    #1;
    check_all();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [NR-1:0] rs;
    int            r;
    cfg_if.cfg_ready = 1'b0;
    model_clear();

    do_reset();
    cyc(8'h04, 0, 0, 0, 0);
    cyc(8'h04, 0, 0, 0, 0);

    // rotor 0 through a full revolution
    cyc(8'h01, 0, 0, 0, 0);
    repeat (26) cyc(8'h00, 1, 0, 0, 0);
    check("pos0_wrapped", 64'(dbg_pos[4:0]), 64'd0);
`ifdef ROTOR_CARRY_EN
    check("pos1_after_wrap", 64'(dbg_pos[9:5]), 64'd1);
`else
    check("pos1_after_wrap", 64'(dbg_pos[9:5]), 64'd0);
`endif

    // rotor 3 borrow wrap, then opposing steps cancel
    cyc(8'h08, 0, 0, 0, 0);
    cyc(8'h00, 0, 1, 0, 0);
    cyc(8'h00, 1, 1, 0, 0);
    check("pos3_down_wrap", 64'(dbg_pos[19:15]), 64'd25);

    // non-one-hot presses in IDLE and EDIT(1)
    cyc(8'h08, 0, 0, 0, 0);
    cyc(8'h05, 0, 0, 0, 0);
    cyc(8'h02, 0, 0, 0, 0);
    cyc(8'h05, 0, 0, 0, 0);

    // rotor 2 to 7, commit, hold off ready while inputs are ignored
    cyc(8'h04, 0, 0, 0, 0);
    repeat (7) cyc(8'h00, 1, 0, 0, 0);
    cyc(8'h00, 0, 0, 1, 0);
    repeat (4) cyc(8'h01, 1, 0, 0, 0);
    check("held_rotor2", 64'(cfg_if.cfg_data[14:10]), 64'd7);
    cyc(8'h00, 0, 0, 0, 1);
    check("valid_drop", 64'(cfg_if.cfg_valid), 64'd0);

    // commit with a step in the same cycle, back-to-back transfers
    cyc(8'h04, 0, 0, 0, 0);
    cyc(8'h00, 1, 0, 1, 0);
    cyc(8'h00, 0, 0, 0, 1);
    cyc(8'h00, 0, 0, 1, 1);
    cyc(8'h00, 0, 0, 0, 1);

    // reset while a transfer is pending
    cyc(8'h00, 0, 0, 1, 0);
    do_reset();
    check("reset_cfg_data", 64'(cfg_if.cfg_data), 64'd0);

    repeat (500) begin
      r = $urandom_range(0, 9);
      if (r >= 6 && r <= 7) rs = NR'(1) << $urandom_range(0, NR - 1);
      else if (r == 8)      rs = NR'($urandom_range(0, 255));
      else                  rs = '0;
      cyc(rs, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
